// File: rtl/mcpu_pkg.sv
// Shared MicroCPU definitions: default widths, fetch FSM states and opcode field layout.
package mcpu_pkg;

    localparam int WORD_SIZE    = 16;
    localparam int ADDR_WIDTH   = 8;
    localparam int OPCODE_WIDTH = 4;

    localparam logic [OPCODE_WIDTH-1:0] HALT_OPCODE = 4'hF;

    // The opcode occupies the top OPCODE_WIDTH bits of an instruction word.
    function automatic int opcode_msb(input int word_size);
        return word_size - 1;
    endfunction

    function automatic int opcode_lsb(input int word_size);
        return word_size - OPCODE_WIDTH;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/mcpu_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones instead of wrapping.
module mcpu_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mcpu_fetch_unit.sv
// MicroCPU instruction fetch stage: PC, instruction register and decode handshake.
// Optional HALT detection is enabled by defining MCPU_FETCH_HALT_DETECT_EN.
module mcpu_fetch_unit
    import mcpu_pkg::*;
#(
    parameter int                    WORD_SIZE  = mcpu_pkg::WORD_SIZE,
    parameter int                    ADDR_WIDTH = mcpu_pkg::ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
`ifdef MCPU_FETCH_HALT_DETECT_EN
    , parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE = mcpu_pkg::HALT_OPCODE
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] instraddr,
    input  logic [WORD_SIZE-1:0]  instrrd,
    output logic [WORD_SIZE-1:0]  instr_out,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [15:0]           fetch_count,
    output logic                  halted,
    output fetch_state_e          state_dbg
);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0]  instr_out_q, instr_out_d;
    logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic                  instr_valid_q, instr_valid_d;
    logic                  advance;

    // Handshake: an instruction transfers on any cycle with instr_valid && instr_ready;
    // once raised, instr_valid and its payload hold until that transfer or a redirect flush.
    assign advance = !instr_valid_q || instr_ready;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_out_d   = instr_out_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                if (start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Redirect wins over both stall and advance and drops the held word.
                if (redirect_valid) begin
                    pc_d          = redirect_pc;
                    instr_valid_d = 1'b0;
                end else if (advance) begin
                    instr_out_d   = instrrd;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    pc_d          = pc_q + 1'b1;
`ifdef MCPU_FETCH_HALT_DETECT_EN
                    if (instrrd[opcode_msb(WORD_SIZE):opcode_lsb(WORD_SIZE)] == HALT_OPCODE) begin
                        state_d = ST_HALTED;
                    end
`endif
                end
            end
`ifdef MCPU_FETCH_HALT_DETECT_EN
            ST_HALTED: begin
                if (redirect_valid) begin
                    pc_d          = redirect_pc;
                    instr_valid_d = 1'b0;
                    state_d       = ST_FETCH;
                end else if (instr_ready) begin
                    instr_valid_d = 1'b0;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            instr_out_q   <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_out_q   <= instr_out_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    mcpu_sat_counter #(
        .WIDTH(16)
    ) u_fetch_count (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (instr_valid_q && instr_ready),
        .count(fetch_count)
    );

`ifdef MCPU_FETCH_HALT_DETECT_EN
    // Report halted only after decode has taken the HALT word itself.
    assign halted = (state_q == ST_HALTED) && !instr_valid_q;
`else
    assign halted = 1'b0;
`endif

    assign instraddr   = pc_q;
    assign instr_out   = instr_out_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_mcpu_fetch_unit.sv
// Directed bench for mcpu_fetch_unit: vector table plus hand-written reset, redirect and halt sequences.
module tb_mcpu_fetch_unit;
    import mcpu_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [7:0]   instraddr;
    logic [15:0]  instrrd;
    logic [15:0]  instr_out;
    logic [7:0]   instr_pc;
    logic         instr_valid;
    logic         instr_ready;
    logic         redirect_valid;
    logic [7:0]   redirect_pc;
    logic [15:0]  fetch_count;
    logic         halted;
    fetch_state_e state_dbg;

    logic         sat_en;
    logic [2:0]   sat_count;

    logic [15:0]  mem [256];

    int checks;
    int errors;

    typedef struct {
        logic        start;
        logic        ready;
        logic        redir;
        logic [7:0]  rpc;
        logic [15:0] e_out;
        logic [7:0]  e_ipc;
        logic        e_valid;
        logic [7:0]  e_addr;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vq[$];

    mcpu_fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .instraddr     (instraddr),
        .instrrd       (instrrd),
        .instr_out     (instr_out),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fetch_count   (fetch_count),
        .halted        (halted),
        .state_dbg     (state_dbg)
    );

    mcpu_sat_counter #(
        .WIDTH(3)
    ) u_sat (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (sat_en),
        .count(sat_count)
    );

    assign instrrd = mem[instraddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        rst_n          = 1'b0;
        start          = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        sat_en         = 1'b0;

        // Expected values: post-edge outputs for the inputs held across that edge.
        vq.push_back('{1, 1, 0, 8'h00, 16'h0000, 8'h00, 0, 8'h00, 16'd0});
        vq.push_back('{0, 1, 0, 8'h00, 16'h1000, 8'h00, 1, 8'h01, 16'd0});
        vq.push_back('{0, 1, 0, 8'h00, 16'h1001, 8'h01, 1, 8'h02, 16'd1});
        vq.push_back('{0, 1, 0, 8'h00, 16'h1002, 8'h02, 1, 8'h03, 16'd2});
        vq.push_back('{0, 1, 0, 8'h00, 16'h1003, 8'h03, 1, 8'h04, 16'd3});
        for (int i = 0; i < 5; i++)
            vq.push_back('{0, 0, 0, 8'h00, 16'h1003, 8'h03, 1, 8'h04, 16'd3});
        vq.push_back('{0, 1, 0, 8'h00, 16'h1004, 8'h04, 1, 8'h05, 16'd4});
        vq.push_back('{0, 0, 1, 8'h40, 16'h1004, 8'h04, 0, 8'h40, 16'd4});
        vq.push_back('{0, 1, 0, 8'h00, 16'h1040, 8'h40, 1, 8'h41, 16'd4});
        vq.push_back('{0, 1, 0, 8'h00, 16'h1041, 8'h41, 1, 8'h42, 16'd5});
        vq.push_back('{0, 1, 1, 8'hFE, 16'h1041, 8'h41, 0, 8'hFE, 16'd6});
        vq.push_back('{0, 1, 0, 8'h00, 16'h10FE, 8'hFE, 1, 8'hFF, 16'd6});
        vq.push_back('{0, 1, 0, 8'h00, 16'h10FF, 8'hFF, 1, 8'h00, 16'd7});
        vq.push_back('{0, 1, 0, 8'h00, 16'h1000, 8'h00, 1, 8'h01, 16'd8});
        vq.push_back('{0, 1, 0, 8'h00, 16'h1001, 8'h01, 1, 8'h02, 16'd9});
        vq.push_back('{1, 1, 0, 8'h00, 16'h1002, 8'h02, 1, 8'h03, 16'd10});

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst instr_out", 32'(instr_out), 32'h0);
        check("rst instr_pc", 32'(instr_pc), 32'h0);
        check("rst instr_valid", 32'(instr_valid), 32'h0);
        check("rst instraddr", 32'(instraddr), 32'h0);
        check("rst fetch_count", 32'(fetch_count), 32'h0);
        check("rst halted", 32'(halted), 32'h0);
        check("rst state", 32'(state_dbg), 32'(ST_IDLE));
        rst_n = 1'b1;
        step();
        check("idle state", 32'(state_dbg), 32'(ST_IDLE));
        check("idle instraddr", 32'(instraddr), 32'h0);

        // Table: streaming, stall, redirect, PC wrap, start ignored in FETCH
        for (int i = 0; i < vq.size(); i++) begin
            start          = vq[i].start;
            instr_ready    = vq[i].ready;
            redirect_valid = vq[i].redir;
            redirect_pc    = vq[i].rpc;
            step();
            check($sformatf("v%0d instr_out", i), 32'(instr_out), 32'(vq[i].e_out));
            check($sformatf("v%0d instr_pc", i), 32'(instr_pc), 32'(vq[i].e_ipc));
            check($sformatf("v%0d instr_valid", i), 32'(instr_valid), 32'(vq[i].e_valid));
            check($sformatf("v%0d instraddr", i), 32'(instraddr), 32'(vq[i].e_addr));
            check($sformatf("v%0d fetch_count", i), 32'(fetch_count), 32'(vq[i].e_cnt));
            check($sformatf("v%0d halted", i), 32'(halted), 32'h0);
            check($sformatf("v%0d state", i), 32'(state_dbg), 32'(ST_FETCH));
        end
        start          = 1'b0;
        redirect_valid = 1'b0;

        // Asynchronous reset mid-fetch around pc 8'h20
        redirect_valid = 1'b1;
        redirect_pc    = 8'h20;
        step();
        redirect_valid = 1'b0;
        step();
        check("pre-rst instr_out", 32'(instr_out), 32'h1020);
        check("pre-rst instraddr", 32'(instraddr), 32'h21);
        #2;
        rst_n = 1'b0;
        #1;
        check("async instr_out", 32'(instr_out), 32'h0);
        check("async instr_pc", 32'(instr_pc), 32'h0);
        check("async instr_valid", 32'(instr_valid), 32'h0);
        check("async instraddr", 32'(instraddr), 32'h0);
        check("async fetch_count", 32'(fetch_count), 32'h0);
        check("async state", 32'(state_dbg), 32'(ST_IDLE));
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check($sformatf("post-rst%0d state", i), 32'(state_dbg), 32'(ST_IDLE));
            check($sformatf("post-rst%0d instraddr", i), 32'(instraddr), 32'h0);
            check($sformatf("post-rst%0d instr_valid", i), 32'(instr_valid), 32'h0);
        end

        // Redirect and start together in IDLE
        redirect_valid = 1'b1;
        redirect_pc    = 8'h30;
        start          = 1'b1;
        step();
        redirect_valid = 1'b0;
        start          = 1'b0;
        check("idle-redir state", 32'(state_dbg), 32'(ST_FETCH));
        check("idle-redir instraddr", 32'(instraddr), 32'h30);
        check("idle-redir instr_valid", 32'(instr_valid), 32'h0);
        step();
        check("idle-redir instr_out", 32'(instr_out), 32'h1030);
        check("idle-redir instr_pc", 32'(instr_pc), 32'h30);
        check("idle-redir instraddr+1", 32'(instraddr), 32'h31);

        // Saturating counter boundary
        sat_en = 1'b1;
        repeat (5) step();
        check("sat count 5", 32'(sat_count), 32'h5);
        repeat (5) step();
        check("sat count hold 7", 32'(sat_count), 32'h7);
        sat_en = 1'b0;

`ifdef MCPU_FETCH_HALT_DETECT_EN
        rst_n = 1'b0;
        #1;
        rst_n       = 1'b1;
        mem[5]      = 16'hF000;
        start       = 1'b1;
        instr_ready = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        check("halt instr_out", 32'(instr_out), 32'hF000);
        check("halt instr_pc", 32'(instr_pc), 32'h5);
        check("halt instraddr", 32'(instraddr), 32'h6);
        check("halt state", 32'(state_dbg), 32'(ST_HALTED));
        check("halt pending halted", 32'(halted), 32'h0);
        instr_ready = 1'b0;
        step();
        check("halt stall valid", 32'(instr_valid), 32'h1);
        check("halt stall halted", 32'(halted), 32'h0);
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("halted%0d halted", i), 32'(halted), 32'h1);
            check($sformatf("halted%0d instraddr", i), 32'(instraddr), 32'h6);
            check($sformatf("halted%0d instr_valid", i), 32'(instr_valid), 32'h0);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 8'h00;
        step();
        redirect_valid = 1'b0;
        check("resume halted", 32'(halted), 32'h0);
        check("resume state", 32'(state_dbg), 32'(ST_FETCH));
        check("resume instraddr", 32'(instraddr), 32'h0);
        step();
        check("resume instr_out", 32'(instr_out), 32'h1000);
        check("resume instr_pc", 32'(instr_pc), 32'h0);
        check("resume instr_valid", 32'(instr_valid), 32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
